// File: rtl/axi4_full_umi_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : axi4_full_umi_arb_pkg
// Desc     : UMI opcode constants, cmd field decode and arbiter state encodings.
// Revision : 1.0 - initial release
//==============================================================================
package axi4_full_umi_arb_pkg;

    localparam logic [4:0] c_umi_req_read    = 5'h01;
    localparam logic [4:0] c_umi_resp_read   = 5'h02;
    localparam logic [4:0] c_umi_req_write   = 5'h03;
    localparam logic [4:0] c_umi_resp_write  = 5'h04;
    localparam logic [4:0] c_umi_req_posted  = 5'h05;

    localparam int c_umi_eom_bit = 22;

    localparam logic [1:0] c_st_arb     = 2'd0;
    localparam logic [1:0] c_st_lock_rd = 2'd1;
    localparam logic [1:0] c_st_lock_wr = 2'd2;

    function automatic logic [4:0] umi_opcode(input logic [31:0] cmd);
        return cmd[4:0];
    endfunction

    function automatic logic umi_eom(input logic [31:0] cmd);
        return cmd[c_umi_eom_bit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_full_umi_arb_rr2.sv
`default_nettype none
//==============================================================================
// Module   : umi_arb_rr2
// Desc     : Two-way round-robin arbiter with lock and eligibility masks.
//            Bit 0 is the rd side, bit 1 the wr side; grant is one-hot.
// Revision : 1.0 - initial release
//==============================================================================
module umi_arb_rr2 (
    input  logic [1:0] i_req,
    input  logic [1:0] i_elig,
    input  logic [1:0] i_lock,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    logic [1:0] w_qual;

    assign w_qual = i_req & i_elig;

    // A locked side may only continue its own burst; i_last=1 means wr won last.
    always_comb begin
        o_grant = 2'b00;
        if (|i_lock) begin
            o_grant = w_qual & i_lock;
        end else if (&w_qual) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else begin
            o_grant = w_qual;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_full_umi_arb.sv
`default_nettype none
//==============================================================================
// Module   : axi4_full_umi_arb
// Desc     : Shares one UMI host port between the AXI4-full rd and wr converters.
// Revision : 1.0 - initial release
//==============================================================================
module axi4_full_umi_arb
    import axi4_full_umi_arb_pkg::*;
#(
    parameter int CW     = 32,
    parameter int DW     = 128,
    parameter int AW     = 64,
    parameter int MAXOUT = 1,
    parameter int OCW    = $clog2(MAXOUT + 1)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          urd_req_valid,
    input  logic [CW-1:0] urd_req_cmd,
    input  logic [AW-1:0] urd_req_dstaddr,
    input  logic [AW-1:0] urd_req_srcaddr,
    input  logic [DW-1:0] urd_req_data,
    output logic          urd_req_ready,
    input  logic          uwr_req_valid,
    input  logic [CW-1:0] uwr_req_cmd,
    input  logic [AW-1:0] uwr_req_dstaddr,
    input  logic [AW-1:0] uwr_req_srcaddr,
    input  logic [DW-1:0] uwr_req_data,
    output logic          uwr_req_ready,
    output logic          urd_resp_valid,
    output logic [CW-1:0] urd_resp_cmd,
    output logic [AW-1:0] urd_resp_dstaddr,
    output logic [AW-1:0] urd_resp_srcaddr,
    output logic [DW-1:0] urd_resp_data,
    input  logic          urd_resp_ready,
    output logic          uwr_resp_valid,
    output logic [CW-1:0] uwr_resp_cmd,
    output logic [AW-1:0] uwr_resp_dstaddr,
    output logic [AW-1:0] uwr_resp_srcaddr,
    output logic [DW-1:0] uwr_resp_data,
    input  logic          uwr_resp_ready,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready,
    output logic          err_unexp
);

    localparam logic [OCW-1:0] c_maxout = OCW'(MAXOUT);

    logic           r_active;
    logic [1:0]     r_state;
    logic           r_last;
    logic [OCW-1:0] r_cnt_rd;
    logic [OCW-1:0] r_cnt_wr;
    logic           r_err;

    logic [1:0]     w_elig;
    logic [1:0]     w_lock;
    logic [1:0]     w_arb_grant;
    logic [1:0]     w_grant;
    logic [CW-1:0]  w_req_cmd;
    logic [4:0]     w_req_op;
    logic           w_req_fire;
    logic           w_req_counted;
    logic           w_inc_rd;
    logic           w_inc_wr;
    logic [4:0]     w_resp_op;
    logic           w_route_rd;
    logic           w_route_wr;
    logic           w_dec_rd;
    logic           w_dec_wr;
    logic           w_drop;

    assign w_elig = {(r_cnt_wr < c_maxout), (r_cnt_rd < c_maxout)};
    assign w_lock = (r_state == c_st_lock_rd) ? 2'b01 :
                    (r_state == c_st_lock_wr) ? 2'b10 : 2'b00;

    umi_arb_rr2 u_arb (
        .i_req   ({uwr_req_valid, urd_req_valid}),
        .i_elig  (w_elig),
        .i_lock  (w_lock),
        .i_last  (r_last),
        .o_grant (w_arb_grant)
    );

    // Request path: zero-cycle pass-through of the granted side.
    assign w_grant           = r_active ? w_arb_grant : 2'b00;
    assign w_req_cmd         = w_grant[1] ? uwr_req_cmd : urd_req_cmd;
    assign uhost_req_valid   = |w_grant;
    assign uhost_req_cmd     = w_req_cmd;
    assign uhost_req_dstaddr = w_grant[1] ? uwr_req_dstaddr : urd_req_dstaddr;
    assign uhost_req_srcaddr = w_grant[1] ? uwr_req_srcaddr : urd_req_srcaddr;
    assign uhost_req_data    = w_grant[1] ? uwr_req_data    : urd_req_data;
    assign urd_req_ready     = w_grant[0] & uhost_req_ready;
    assign uwr_req_ready     = w_grant[1] & uhost_req_ready;

    assign w_req_fire    = uhost_req_valid & uhost_req_ready;
    assign w_req_op      = umi_opcode(w_req_cmd);
    assign w_req_counted = (w_req_op == c_umi_req_read) | (w_req_op == c_umi_req_write);
    assign w_inc_rd      = w_req_fire & w_grant[0] & w_req_counted;
    assign w_inc_wr      = w_req_fire & w_grant[1] & w_req_counted;

    // Response path: routed by opcode, dropped when nothing is outstanding.
    assign w_resp_op  = umi_opcode(uhost_resp_cmd);
    assign w_route_rd = r_active & (w_resp_op == c_umi_resp_read)  & (r_cnt_rd != '0);
    assign w_route_wr = r_active & (w_resp_op == c_umi_resp_write) & (r_cnt_wr != '0);

    assign urd_resp_valid   = w_route_rd & uhost_resp_valid;
    assign uwr_resp_valid   = w_route_wr & uhost_resp_valid;
    assign uhost_resp_ready = r_active & (w_route_rd ? urd_resp_ready :
                                          w_route_wr ? uwr_resp_ready : 1'b1);

    assign urd_resp_cmd     = uhost_resp_cmd;
    assign urd_resp_dstaddr = uhost_resp_dstaddr;
    assign urd_resp_srcaddr = uhost_resp_srcaddr;
    assign urd_resp_data    = uhost_resp_data;
    assign uwr_resp_cmd     = uhost_resp_cmd;
    assign uwr_resp_dstaddr = uhost_resp_dstaddr;
    assign uwr_resp_srcaddr = uhost_resp_srcaddr;
    assign uwr_resp_data    = uhost_resp_data;

    assign w_dec_rd = urd_resp_valid & urd_resp_ready;
    assign w_dec_wr = uwr_resp_valid & uwr_resp_ready;
    assign w_drop   = uhost_resp_valid & uhost_resp_ready & ~w_route_rd & ~w_route_wr;

    assign err_unexp = r_err;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_active <= 1'b0;
            r_state  <= c_st_arb;
            r_last   <= 1'b1;
            r_cnt_rd <= '0;
            r_cnt_wr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_drop) begin
                r_err <= 1'b1;
            end
            // Lock is held until the EOM beat so bursts never interleave.
            if (w_req_fire) begin
                if (umi_eom(w_req_cmd)) begin
                    r_state <= c_st_arb;
                    r_last  <= w_grant[1];
                end else begin
                    r_state <= w_grant[1] ? c_st_lock_wr : c_st_lock_rd;
                end
            end
            case ({w_inc_rd, w_dec_rd})
                2'b10:   r_cnt_rd <= r_cnt_rd + OCW'(1);
                2'b01:   r_cnt_rd <= r_cnt_rd - OCW'(1);
                default: r_cnt_rd <= r_cnt_rd;
            endcase
            case ({w_inc_wr, w_dec_wr})
                2'b10:   r_cnt_wr <= r_cnt_wr + OCW'(1);
                2'b01:   r_cnt_wr <= r_cnt_wr - OCW'(1);
                default: r_cnt_wr <= r_cnt_wr;
            endcase
        end
    end

endmodule
`default_nettype wire
